// File: rtl/sel_enc_pkg.sv
// Shared types and constants for the register select sequencer.
// Field codes, FSM state encoding, default IR field positions and a
// helper that sizes the hold counter.
package sel_enc_pkg;

    typedef enum logic [1:0] {
        FIELD_A   = 2'd0,
        FIELD_B   = 2'd1,
        FIELD_C   = 2'd2,
        FIELD_INV = 2'd3
    } field_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam int DEF_RA_LSB = 23;
    localparam int DEF_RB_LSB = 19;
    localparam int DEF_RC_LSB = 15;

    // Width needed to hold the value hold-1 (at least one bit).
    function automatic int hold_cnt_width(input int hold);
        if (hold > 1) begin
            return $clog2(hold);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/reg_select_sequencer_onehot_decoder.sv
// Index-to-one-hot decoder. An index at or beyond NUM_REGS, or a
// deasserted enable, yields an all-zero vector.
module onehot_decoder #(
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // Compare the index against every output position; out-of-range matches nothing.
    always_comb begin
        o_onehot = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_en && (32'(i_idx) == 32'(i))) begin
                o_onehot[i] = 1'b1;
            end else begin
                o_onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_select_sequencer.sv
// Register select sequencer: latches the instruction word, decodes Ra/Rb/Rc
// select commands into registered one-hot register-file enables held for
// HOLD_CYCLES cycles, flags malformed commands, and sign-extends the C immediate.
// Optional feature: define R0_BASE_EN to route base-address reads of R0 to
// r0_zero instead of r_out[0]; without it sel_baout behaves like sel_rout.
module reg_select_sequencer
    import sel_enc_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int IDX_W       = 4,
    parameter int RA_LSB      = DEF_RA_LSB,
    parameter int RB_LSB      = DEF_RB_LSB,
    parameter int RC_LSB      = DEF_RC_LSB,
    parameter int IMM_W       = 19,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [DATA_W-1:0]   ir_in,
    input  logic                ir_load,
    input  logic                sel_valid,
    output logic                sel_ready,
    input  logic [1:0]          sel_field,
    input  logic                sel_rin,
    input  logic                sel_rout,
    input  logic                sel_baout,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                r0_zero,
    output logic [DATA_W-1:0]   c_sign_extended,
    output logic                err_pulse
);

    localparam int CNT_W = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [DATA_W-1:0]   r_ir;
    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REGS-1:0] r_we;
    logic [NUM_REGS-1:0] r_re;
    logic                r_r0z;
    logic                r_err;

    field_e              w_field;
    logic [IDX_W-1:0]    w_ra;
    logic [IDX_W-1:0]    w_rb;
    logic [IDX_W-1:0]    w_rc;
    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_out_req;
    logic                w_r0z_req;
    logic                w_accept;
    logic [NUM_REGS-1:0] w_in_onehot;
    logic [NUM_REGS-1:0] w_out_onehot;
    logic                w_unused_ir;

    assign w_field   = field_e'(sel_field);
    assign w_ra      = r_ir[RA_LSB +: IDX_W];
    assign w_rb      = r_ir[RB_LSB +: IDX_W];
    assign w_rc      = r_ir[RC_LSB +: IDX_W];
    assign w_accept  = sel_valid & (r_state == ST_IDLE);
    // Not every IR bit feeds a field or the immediate; fold them so none dangle.
    assign w_unused_ir = ^r_ir;

    // Pick the register index named by the command's field code.
    always_comb begin
        case (w_field)
            FIELD_A: w_idx = w_ra;
            FIELD_B: w_idx = w_rb;
            FIELD_C: w_idx = w_rc;
            default: w_idx = {IDX_W{1'b0}};
        endcase
    end

    // Classify the command: bad field, out-of-range index or read/write conflict.
    always_comb begin
        w_err = 1'b0;
        if (w_field == FIELD_INV) begin
            w_err = 1'b1;
        end else if (32'(w_idx) >= 32'(NUM_REGS)) begin
            w_err = 1'b1;
        end else if (sel_rin && (sel_rout || sel_baout)) begin
            w_err = 1'b1;
        end else begin
            w_err = 1'b0;
        end
    end

    // Route read requests: a base-address read of R0 may be diverted to r0_zero.
    always_comb begin
`ifdef R0_BASE_EN
        w_out_req = sel_rout | (sel_baout & (w_idx != {IDX_W{1'b0}}));
        w_r0z_req = sel_baout & (w_idx == {IDX_W{1'b0}}) & ~w_err;
`else
        w_out_req = sel_rout | sel_baout;
        w_r0z_req = 1'b0;
`endif
    end

    onehot_decoder #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec_in (
        .i_idx    (w_idx),
        .i_en     (sel_rin & ~w_err),
        .o_onehot (w_in_onehot)
    );

    onehot_decoder #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec_out (
        .i_idx    (w_idx),
        .i_en     (w_out_req & ~w_err),
        .o_onehot (w_out_onehot)
    );

    // Instruction register: loads whenever requested, independent of the FSM.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_ir <= {DATA_W{1'b0}};
        end else if (ir_load) begin
            r_ir <= ir_in;
        end else begin
            r_ir <= r_ir;
        end
    end

    // Command FSM: accept in IDLE, hold the registered enables in DRIVE, then release.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_we    <= {NUM_REGS{1'b0}};
            r_re    <= {NUM_REGS{1'b0}};
            r_r0z   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_DRIVE;
                        r_cnt   <= CNT_LOAD;
                        r_we    <= w_in_onehot;
                        r_re    <= w_out_onehot;
                        r_r0z   <= w_r0z_req;
                        r_err   <= w_err;
                    end else begin
                        r_err   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_err <= 1'b0;
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_we    <= {NUM_REGS{1'b0}};
                        r_re    <= {NUM_REGS{1'b0}};
                        r_r0z   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_we    <= {NUM_REGS{1'b0}};
                    r_re    <= {NUM_REGS{1'b0}};
                    r_r0z   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_ready       = (r_state == ST_IDLE);
    assign r_in            = r_we;
    assign r_out           = r_re;
    assign r0_zero         = r_r0z;
    assign err_pulse       = r_err;
    assign c_sign_extended = {{(DATA_W - IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};

endmodule
